// File: rtl/spi_pkg.sv
// Shared SPI frame layout, command codes and slave FSM states; also used by spi_master.
package spi_pkg;

  localparam int unsigned DEF_FRAME_BITS = 24;
  localparam int unsigned DEF_ADDR_W     = 4;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned CMD_W          = 4;

  localparam logic [CMD_W-1:0] CMD_WRITE = 4'b1000;
  localparam logic [CMD_W-1:0] CMD_READ  = 4'b0000;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StCommit = 2'd2,
    StWaitCs = 2'd3
  } spi_state_e;

  // On-wire order, MSB first: cmd, addr, data.
  typedef struct packed {
    logic [CMD_W-1:0]      cmd;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } spi_frame_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage pin synchronizer with a trailing history flop for rise/fall detection.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = async_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave writing a 16-entry register file from 24-bit frames.
// Optional MISO readback of CMD_READ frames is enabled by defining SPI_SLAVE_READBACK_EN.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned       NumRegs   = 2 ** ADDR_W;
  localparam int unsigned       CntW      = $clog2(FRAME_BITS + 2);
  localparam logic [CntW-1:0]   CntFull   = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0]   CntSat    = CntW'(FRAME_BITS + 1);
  localparam int unsigned       SettleW   = $clog2(SYNC_STAGES + 2);
  localparam logic [SettleW-1:0] SettleMax = SettleW'(SYNC_STAGES + 1);
`ifdef SPI_SLAVE_READBACK_EN
  localparam bit ReadbackEn = 1'b1;
`else
  localparam bit ReadbackEn = 1'b0;
`endif

  logic cs_sync, cs_rise, cs_fall;
  logic sck_sync, sck_rise, sck_fall;
  logic mosi_sync;

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .async_i   (spi_cs),
    .sync_o    (cs_sync),
    .rise_o    (cs_rise),
    .fall_o    (cs_fall)
  );

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sck_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .async_i   (spi_sck),
    .sync_o    (sck_sync),
    .rise_o    (sck_rise),
    .fall_o    (sck_fall)
  );

  // MOSI needs no edge detect; its chain keeps it aligned with sck_rise.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  always_comb begin
    mosi_sync_d    = mosi_sync_q;
    mosi_sync_d[0] = spi_mosi;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      mosi_sync_d[i] = mosi_sync_q[i-1];
    end
  end

  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e               state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]    shift_q, shift_d;
  logic [SettleW-1:0]       settle_q, settle_d;
  logic [DATA_W-1:0]        regs_q [NumRegs];
  logic [DATA_W-1:0]        regs_d [NumRegs];
  logic                     wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d;
  logic                     frame_err_q, frame_err_d;
  logic [DATA_W-1:0]        rd_data_q, rd_data_d;

  logic [CMD_W-1:0]  frame_cmd;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              frame_full, is_write, is_read;

  assign frame_cmd  = shift_q[FRAME_BITS-1 -: CMD_W];
  assign frame_addr = shift_q[DATA_W +: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign frame_full = (cnt_q == CntFull);
  assign is_write   = frame_full && (frame_cmd == CMD_WRITE);
  assign is_read    = frame_full && (frame_cmd == CMD_READ) && ReadbackEn;

  // Synchronizer outputs hold reset values for a few cycles; cs is not trusted until then.
  always_comb begin
    settle_d = settle_q;
    if (settle_q != SettleMax) begin
      settle_d = settle_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    rd_data_d   = regs_q[rd_addr];

    case (state_q)
      StWaitCs: begin
        if ((settle_q == SettleMax) && cs_sync) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (cs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StShift: begin
        if (cs_rise) begin
          state_d = StCommit;
        end else if (sck_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_sync};
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCommit: begin
        if (is_write) begin
          wr_valid_d         = 1'b1;
          wr_addr_d          = frame_addr;
          wr_data_d          = frame_data;
          regs_d[frame_addr] = frame_data;
        end else if (!is_read) begin
          frame_err_d = 1'b1;
        end
        if (cs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StWaitCs;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mosi_sync_q <= '0;
      state_q     <= StWaitCs;
      cnt_q       <= '0;
      shift_q     <= '0;
      settle_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      settle_q    <= settle_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      rd_data_q   <= rd_data_d;
      regs_q      <= regs_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign rd_data   = rd_data_q;

`ifdef SPI_SLAVE_READBACK_EN
  logic [DATA_W-1:0] miso_shift_q, miso_shift_d;
  logic [CntW-1:0]   miso_left_q, miso_left_d;
  logic              miso_q, miso_d;
  logic              load_rd;

  // Command and address are complete on the rise that brings the count to CMD_W+ADDR_W.
  assign load_rd = (state_q == StShift) && sck_rise && !cs_rise &&
                   (cnt_q == CntW'(CMD_W + ADDR_W - 1)) &&
                   (shift_d[CMD_W+ADDR_W-1 -: CMD_W] == CMD_READ);

  always_comb begin
    miso_shift_d = miso_shift_q;
    miso_left_d  = miso_left_q;
    miso_d       = miso_q;
    if (state_q != StShift) begin
      miso_d      = 1'b0;
      miso_left_d = '0;
    end else if (load_rd) begin
      miso_shift_d = regs_q[shift_d[ADDR_W-1:0]];
      miso_left_d  = CntW'(DATA_W);
    end else if (sck_fall) begin
      if (miso_left_q != '0) begin
        miso_d       = miso_shift_q[DATA_W-1];
        miso_shift_d = {miso_shift_q[DATA_W-2:0], 1'b0};
        miso_left_d  = miso_left_q - 1'b1;
      end else begin
        miso_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      miso_shift_q <= '0;
      miso_left_q  <= '0;
      miso_q       <= 1'b0;
    end else begin
      miso_shift_q <= miso_shift_d;
      miso_left_q  <= miso_left_d;
      miso_q       <= miso_d;
    end
  end

  assign spi_miso = miso_q;
`else
  logic unused_sck_fall;
  assign unused_sck_fall = sck_fall;
  assign spi_miso        = 1'b0;
`endif

  logic unused_sck_sync;
  assign unused_sck_sync = sck_sync;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: expected write/error events are queued per frame
// and popped as the DUT pulses wr_valid or frame_err.
module tb_spi_slave_regfile;

  localparam int CLK_PER = 20;
  localparam int HALF    = 100;
  localparam int SYNC    = 2;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        spi_cs    = 1'b1;
  logic        spi_sck   = 1'b0;
  logic        spi_mosi  = 1'b0;
  logic        spi_miso;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic [3:0]  rd_addr   = 4'd0;
  logic [15:0] rd_data;

  spi_slave_regfile #(
    .FRAME_BITS  (24),
    .ADDR_W      (4),
    .DATA_W      (16),
    .SYNC_STAGES (SYNC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .spi_cs    (spi_cs),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #(CLK_PER / 2) sys_clk = ~sys_clk;

  typedef struct packed {
    logic        is_err;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         ev;
  logic [15:0] model [16];
  logic [31:0] miso_vec;
  time         t_rise;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [15:0] d);
    exp_q.push_back('{is_err: 1'b0, addr: a, data: d});
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, addr: 4'd0, data: 16'd0});
  endtask

  task automatic drain();
    check_eq("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic cs_low();
    @(negedge sys_clk);
    spi_cs = 1'b0;
  endtask

  // Bit i of the frame is val[nbits-1-i]; MISO is sampled just before each rising edge.
  task automatic shift_bits(input logic [31:0] val, input int nbits, input int first,
                            input int last);
    for (int i = first; i < last; i++) begin
      spi_mosi = val[nbits-1-i];
      #HALF;
      miso_vec[nbits-1-i] = spi_miso;
      spi_sck = 1'b1;
      #HALF;
      spi_sck = 1'b0;
    end
  endtask

  // quick=1 releases cs for one sys_clk only, so the next fall lands in COMMIT.
  task automatic cs_high(input bit quick);
    #HALF;
    @(negedge sys_clk);
    spi_cs = 1'b1;
    t_rise = $time;
    if (quick) begin
      @(negedge sys_clk);
      spi_cs = 1'b0;
    end else begin
      repeat (25) @(negedge sys_clk);
    end
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits, input bit quick);
    cs_low();
    miso_vec = '0;
    shift_bits(val, nbits, 0, nbits);
    cs_high(quick);
  endtask

  task automatic read_reg(input logic [3:0] a, input logic [15:0] exp);
    @(negedge sys_clk);
    rd_addr = a;
    @(negedge sys_clk);
    check_eq($sformatf("reg%0d", a), rd_data, exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_wr_valid"}, wr_valid, 0);
    check_eq({tag, "_frame_err"}, frame_err, 0);
    check_eq({tag, "_wr_addr"}, wr_addr, 0);
    check_eq({tag, "_wr_data"}, wr_data, 0);
    check_eq({tag, "_rd_data"}, rd_data, 0);
    check_eq({tag, "_miso"}, spi_miso, 0);
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n && (wr_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_evt", {30'd0, wr_valid, frame_err}, 0);
      end else begin
        ev = exp_q.pop_front();
        check_eq("evt_kind", {30'd0, wr_valid, frame_err}, ev.is_err ? 32'd1 : 32'd2);
        if (!ev.is_err) begin
          check_eq("wr_addr", wr_addr, ev.addr);
          check_eq("wr_data", wr_data, ev.data);
          check_eq("wr_latency", 32'(($time - t_rise) / CLK_PER), SYNC + 2);
          if (rd_addr == ev.addr) begin
            check_eq("rd_old_on_collision", rd_data, model[ev.addr]);
          end
          model[ev.addr] = ev.data;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    miso_vec = '0;
    t_rise   = 0;

    repeat (3) @(negedge sys_clk);
    check_outputs_zero("rst");
    sys_rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    check_outputs_zero("post_rst");

    // Basic write; rd_addr already on 4 to exercise same-cycle read of the old value.
    rd_addr = 4'd4;
    expect_wr(4'd4, 16'hE6B7);
    send_frame(32'h84E6B7, 24, 1'b0);
    drain();
    @(negedge sys_clk);
    rd_addr = 4'd0;
    @(negedge sys_clk);
    check_eq("rd_addr0", rd_data, 0);
    rd_addr = 4'd4;
    #1;
    check_eq("rd_latency_old", rd_data, 0);
    @(negedge sys_clk);
    check_eq("rd_addr4", rd_data, 16'hE6B7);

    // Short frame: first 17 bits of 0x85AAAA.
    expect_err();
    send_frame(32'h85AAAA >> 7, 17, 1'b0);
    drain();
    read_reg(4'd5, 16'h0000);

    // Overrun: 26 bits with a write command.
    expect_err();
    send_frame((32'h855555 << 2) | 32'h3, 26, 1'b0);
    drain();
    read_reg(4'd5, 16'h0000);

    // Unsupported command.
    expect_err();
    send_frame(32'h34FFFF, 24, 1'b0);
    drain();
    read_reg(4'd4, 16'hE6B7);

    // Read command: readback when enabled, otherwise rejected.
`ifdef SPI_SLAVE_READBACK_EN
    send_frame(32'h040000, 24, 1'b0);
    drain();
    check_eq("miso_readback", miso_vec, 32'h0000E6B7);
`else
    expect_err();
    send_frame(32'h040000, 24, 1'b0);
    drain();
    check_eq("miso_idle", miso_vec, 0);
`endif
    read_reg(4'd4, 16'hE6B7);

    // Back-to-back frames: cs high for one cycle, next fall arrives during COMMIT.
    expect_wr(4'd2, 16'h1111);
    expect_wr(4'd3, 16'h2222);
    send_frame(32'h821111, 24, 1'b1);
    send_frame(32'h832222, 24, 1'b0);
    drain();
    read_reg(4'd2, 16'h1111);
    read_reg(4'd3, 16'h2222);

    // Reset mid-frame at bit 10; remainder of the frame must be ignored silently.
    read_reg(4'd4, 16'hE6B7);
    cs_low();
    shift_bits(32'h87BEEF, 24, 0, 10);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_outputs_zero("mid_rst");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    shift_bits(32'h87BEEF, 24, 10, 24);
    cs_high(1'b0);
    drain();
    read_reg(4'd7, 16'h0000);
    read_reg(4'd4, 16'h0000);

    expect_wr(4'd7, 16'hBEEF);
    send_frame(32'h87BEEF, 24, 1'b0);
    drain();
    read_reg(4'd7, 16'hBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  FRAME_BITS  24  bits per SPI frame: cmd[23:20], addr[19:16], data[15:0]
  ADDR_W      4   register address width, 16 registers
  DATA_W      16  register width
  SYNC_STAGES 2   flip-flop stages in each pin synchronizer
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  sys_clk    in  1      system clock, 50 MHz; the reset is sys_rst_n, asynchronous, active-low; the clock is sys_clk
  sys_rst_n  in  1      asynchronous active-low reset
  spi_cs     in  1      chip select, active-low, asynchronous to sys_clk
  spi_sck    in  1      SPI clock, mode 0, at most sys_clk/10
  spi_mosi   in  1      serial data, MSB first
  spi_miso   out 1      serial readback data
  wr_valid   out 1      one-cycle pulse on a committed write
  wr_addr    out ADDR_W address of the committed write
  wr_data    out DATA_W data of the committed write
  frame_err  out 1      one-cycle pulse on a bad frame
  rd_addr    in  ADDR_W host read address
  rd_data    out DATA_W registered register contents at rd_addr

Function
REQ-003 spi_cs, spi_sck and spi_mosi SHALL each pass through SYNC_STAGES flip-flops, followed by one edge-detect register.
REQ-004 The FSM SHALL have states IDLE, SHIFT, COMMIT and WAIT_CS.
  IDLE->SHIFT on a synchronized cs falling edge.
  SHIFT->COMMIT on a cs rising edge.
  COMMIT->IDLE after one cycle.
  WAIT_CS->IDLE when synchronized cs is high.
REQ-005 In SHIFT, each synchronized sck rising edge SHALL shift mosi into a 24-bit register MSB first and increment a 5-bit bit counter; the counter saturates at 25.
REQ-006 In COMMIT with bit count == 24 and cmd == CMD_WRITE (4'b1000), the block SHALL write reg[addr] <= data and pulse wr_valid with wr_addr/wr_data for exactly one cycle.
REQ-007 In COMMIT, the block SHALL pulse frame_err and write nothing if:
  bit count != 24 (short frame or overrun), or
  cmd is not a supported command.
REQ-008 In COMMIT with count == 24 and cmd == CMD_READ (4'b0000), the block SHALL write nothing and raise no error.
REQ-009 Latency: wr_valid SHALL assert exactly SYNC_STAGES+2 sys_clk cycles after spi_cs rises at the pin.
REQ-010 rd_data SHALL equal reg[rd_addr] registered, with 1-cycle latency.
REQ-011 If a write commit and a host read hit the same address in the same cycle, rd_data SHALL return the old value.
REQ-012 sck edges while cs is high SHALL be ignored.
REQ-013 A cs falling edge that arrives during COMMIT SHALL be honoured, and the FSM SHALL go directly to SHIFT.

Reset
REQ-014 While sys_rst_n is low, all registers SHALL reset: regs=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0, rd_data=0, spi_miso=0, FSM=WAIT_CS, counter=0, synchronizer outputs (cs high, sck low, mosi low).
REQ-015 The block SHALL leave reset in WAIT_CS, so a frame already in progress is discarded without frame_err.

Configuration
REQ-016 Macro SPI_SLAVE_READBACK_EN controls readback, with the following behaviour:
  Defined: on the 8th sck rising edge of a CMD_READ frame, reg[addr] loads an output shifter; spi_miso presents its MSB on each following sck falling edge (bits 8..23); spi_miso=0 otherwise.
  Undefined: spi_miso is tied 0 and CMD_READ is unsupported per REQ-007.

Structure
REQ-017 Package spi_pkg SHALL hold:
  CMD_WRITE and CMD_READ
  FRAME_BITS, ADDR_W, DATA_W defaults
  the FSM state enum
  this frame layout, shared with spi_master
REQ-018 Sub-module spi_sync_edge SHALL hold the synchronizer plus rise/fall detect; it is instantiated once each for cs and sck (mosi uses the sync-only path).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  Write 0x84E6B7 at 5 MHz -> one wr_valid, wr_addr=4, wr_data=0xE6B7; then rd_addr=4 -> rd_data=0xE6B7 one cycle later.
  cs deasserted after 17 bits -> frame_err pulse, no wr_valid, reg unchanged.
  26 bits with cmd 1000 -> frame_err, no write.
  Cmd 0x3 -> frame_err; with READBACK_EN undefined, cmd 0x0 -> frame_err and miso stays 0.
  With READBACK_EN, reg[4]=0xE6B7, read frame 0x040000 -> miso bits 8..23 = 1110011010110111, no wr_valid.
  Reset pulsed mid-frame at bit 10 -> all outputs 0; the remainder of that frame causes no write or error; the next full frame writes normally.
